// File: rtl/if_pkg.sv
// Shared types and constants for the instruction-fetch front end.
package if_pkg;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    TRAP = 2'd2
  } fetch_state_t;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  localparam logic [31:0] PC_STEP   = 32'd4;

endpackage

// File: rtl/if_fifo.sv
// Prefetch buffer: DEPTH x {pc, instr} synchronous FIFO with flush and occupancy count.
// DEPTH must be a power of 2 so the pointers wrap naturally.
module if_fifo #(
  parameter int DEPTH = 2,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          flush,
  input  logic          push,
  input  logic [31:0]   push_pc,
  input  logic [31:0]   push_instr,
  input  logic          pop,
  output logic [31:0]   head_pc,
  output logic [31:0]   head_instr,
  output logic [CW-1:0] count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [63:0]   mem_r [DEPTH];
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [CW-1:0] count_r;

  // Storage, pointers and occupancy; flush discards everything in one edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= 64'd0;
      end
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else if (flush) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else begin
      if (push) begin
        mem_r[wr_ptr_r] <= {push_pc, push_instr};
        wr_ptr_r        <= wr_ptr_r + {{(AW-1){1'b0}}, 1'b1};
      end
      if (pop) begin
        rd_ptr_r <= rd_ptr_r + {{(AW-1){1'b0}}, 1'b1};
      end
      case ({push, pop})
        2'b10:   count_r <= count_r + {{(CW-1){1'b0}}, 1'b1};
        2'b01:   count_r <= count_r - {{(CW-1){1'b0}}, 1'b1};
        default: count_r <= count_r;
      endcase
    end
  end

  assign head_pc    = mem_r[rd_ptr_r][63:32];
  assign head_instr = mem_r[rd_ptr_r][31:0];
  assign count      = count_r;

endmodule

// File: rtl/if_prefetch.sv
// Instruction-fetch front end: issues ROM reads, buffers words with PCs, serves ID via valid/ready.
// Optional IF_MISALIGN_TRAP_EN: misaligned redirect targets raise a trap marker instead of fetching.
module if_prefetch
  import if_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic        rom_en,
  output logic [31:0] rom_addr,
  input  logic [31:0] rom_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc
`ifdef IF_MISALIGN_TRAP_EN
  ,
  output logic        id_misalign
`endif
);

  localparam int            CW        = $clog2(DEPTH + 1);
  localparam logic [CW:0]   DEPTH_OCC = (CW + 1)'(DEPTH);

  fetch_state_t  state_r, state_s;
  logic [31:0]   fetch_pc_r, fetch_pc_s;
  logic [31:0]   issue_pc_r, issue_pc_s;
  logic          inflight_r, inflight_s;

  logic          push_s, pop_s, flush_s;
  logic [31:0]   head_pc_s, head_instr_s;
  logic [CW-1:0] count_s;
  logic [CW:0]   occ_s;
  logic [31:0]   tgt_pc_s;
  logic          bad_tgt_s;

`ifdef IF_MISALIGN_TRAP_EN
  logic [31:0]   trap_pc_r, trap_pc_s;
  logic          misalign_s;

  assign tgt_pc_s    = redirect_pc;
  assign bad_tgt_s   = |redirect_pc[1:0];
  assign id_misalign = misalign_s;
`else
  logic          unused_lo_s;

  assign tgt_pc_s    = {redirect_pc[31:2], 2'b00};
  assign bad_tgt_s   = 1'b0;
  assign unused_lo_s = ^redirect_pc[1:0];
`endif

  // Words already buffered plus the one on its way back from the ROM.
  assign occ_s = {1'b0, count_s} + {{CW{1'b0}}, inflight_r};

  if_fifo #(
    .DEPTH (DEPTH),
    .CW    (CW)
  ) u_fifo (
    .clk        (clk),
    .reset_n    (reset_n),
    .flush      (flush_s),
    .push       (push_s),
    .push_pc    (issue_pc_r),
    .push_instr (rom_data),
    .pop        (pop_s),
    .head_pc    (head_pc_s),
    .head_instr (head_instr_s),
    .count      (count_s)
  );

  // Next-state, issue and ID-side outputs; a redirect overrides everything else.
  always_comb begin
    state_s    = state_r;
    fetch_pc_s = fetch_pc_r;
    issue_pc_s = issue_pc_r;
    inflight_s = 1'b0;
    rom_en     = 1'b0;
    rom_addr   = fetch_pc_r;
    flush_s    = 1'b0;
    push_s     = 1'b0;
    pop_s      = 1'b0;
    id_valid   = 1'b0;
    id_instr   = NOP_INSTR;
    id_pc      = 32'h0000_0000;
`ifdef IF_MISALIGN_TRAP_EN
    trap_pc_s  = trap_pc_r;
    misalign_s = 1'b0;
`endif

    if (redirect_valid) begin
      flush_s = 1'b1;
      if (bad_tgt_s) begin
        state_s = TRAP;
`ifdef IF_MISALIGN_TRAP_EN
        trap_pc_s = redirect_pc;
`endif
      end else begin
        state_s    = RUN;
        rom_en     = 1'b1;
        rom_addr   = tgt_pc_s;
        issue_pc_s = tgt_pc_s;
        fetch_pc_s = tgt_pc_s + PC_STEP;
        inflight_s = 1'b1;
      end
    end else begin
      case (state_r)
        BOOT: begin
          state_s = RUN;
        end
        RUN: begin
          if (count_s != {CW{1'b0}}) begin
            id_valid = 1'b1;
            id_instr = head_instr_s;
            id_pc    = head_pc_s;
          end else begin
            id_valid = 1'b0;
          end
          pop_s  = id_valid & id_ready;
          push_s = inflight_r;
          // A pop this cycle frees the slot the new request will land in.
          if ((occ_s < DEPTH_OCC) || pop_s) begin
            rom_en     = 1'b1;
            rom_addr   = fetch_pc_r;
            issue_pc_s = fetch_pc_r;
            fetch_pc_s = fetch_pc_r + PC_STEP;
            inflight_s = 1'b1;
          end else begin
            rom_en = 1'b0;
          end
        end
`ifdef IF_MISALIGN_TRAP_EN
        TRAP: begin
          id_valid   = 1'b1;
          id_instr   = NOP_INSTR;
          id_pc      = trap_pc_r;
          misalign_s = 1'b1;
        end
`endif
        default: begin
          state_s = BOOT;
        end
      endcase
    end
  end

  // Fetch state registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r    <= BOOT;
      fetch_pc_r <= RESET_PC;
      issue_pc_r <= 32'h0000_0000;
      inflight_r <= 1'b0;
    end else begin
      state_r    <= state_s;
      fetch_pc_r <= fetch_pc_s;
      issue_pc_r <= issue_pc_s;
      inflight_r <= inflight_s;
    end
  end

`ifdef IF_MISALIGN_TRAP_EN
  // Faulting target held for reporting while trapped.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      trap_pc_r <= 32'h0000_0000;
    end else begin
      trap_pc_r <= trap_pc_s;
    end
  end
`endif

endmodule
